// File: rtl/exu_decq.sv
// Decode queue: circular FIFO of raw fetched instructions with combinational RV32I decode of the head entry.
// Define DECQ_MULDIV_EN to decode funct7=0000001 OP instructions as MULDIV; otherwise they are illegal.
module exu_decq #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PC_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [31:0]             i_instr,
  input  logic [PC_W-1:0]         i_pc,
  input  logic                    i_prdt_taken,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [PC_W-1:0]         o_pc,
  output logic                    o_prdt_taken,
  output logic                    o_rs1en,
  output logic                    o_rs2en,
  output logic                    o_rdwen,
  output logic [4:0]              o_rs1idx,
  output logic [4:0]              o_rs2idx,
  output logic [4:0]              o_rdidx,
  output logic [1:0]              o_grp,
  output logic [31:0]             o_imm,
  output logic                    o_illegal,
  output logic                    o_bjp,
  output logic [$clog2(DEPTH):0]  o_cnt,
  output logic [15:0]             o_ill_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = 32 + PC_W + 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
`ifdef DECQ_MULDIV_EN
  localparam logic [6:0] F7_MD      = 7'b0000001;
`endif

  localparam logic [1:0] GRP_ALU = 2'b00;
  localparam logic [1:0] GRP_BJP = 2'b01;
  localparam logic [1:0] GRP_AGU = 2'b10;
`ifdef DECQ_MULDIV_EN
  localparam logic [1:0] GRP_MDV = 2'b11;
`endif

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   ill_cnt_q, ill_cnt_d;

  logic          push, pop;
  logic [EW-1:0] entry_d, head;
  logic [31:0]   instr;
  logic [6:0]    opc, funct7;
  logic [2:0]    funct3;
  logic [31:0]   imm_i, imm_s, imm_b, imm_u, imm_j;

  logic          dec_ill, dec_bjp, dec_rs1en, dec_rs2en, dec_rdwen;
  logic [1:0]    dec_grp;
  logic [31:0]   dec_imm;

  assign i_ready = (cnt_q < CW'(DEPTH));
  assign o_valid = (cnt_q != '0);
  assign push    = i_valid & i_ready;
  assign pop     = o_valid & o_ready;
  assign entry_d = {i_prdt_taken, i_pc, i_instr};
  assign head    = mem_q[rptr_q];

  // Raw entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= entry_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      ill_cnt_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  // Pointer/occupancy update; flush wins over any push in the same cycle.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    ill_cnt_d = ill_cnt_q;
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
      if (dec_ill && (ill_cnt_q != 16'hFFFF)) ill_cnt_d = ill_cnt_q + 16'd1;
    end
    if (push) wptr_d = wptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  assign instr  = head[31:0];
  assign opc    = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'h000};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Head decode; illegal or empty-queue cases force every control to zero.
  always_comb begin
    dec_ill   = 1'b0;
    dec_grp   = GRP_ALU;
    dec_bjp   = 1'b0;
    dec_rs1en = 1'b0;
    dec_rs2en = 1'b0;
    dec_rdwen = 1'b0;
    dec_imm   = '0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        dec_rdwen = 1'b1;
        dec_imm   = imm_u;
      end
      OPC_JAL: begin
        dec_grp = GRP_BJP; dec_bjp = 1'b1; dec_rdwen = 1'b1; dec_imm = imm_j;
      end
      OPC_JALR: begin
        dec_grp = GRP_BJP; dec_bjp = 1'b1; dec_rs1en = 1'b1; dec_rdwen = 1'b1; dec_imm = imm_i;
      end
      OPC_BRANCH: begin
        dec_grp = GRP_BJP; dec_bjp = 1'b1; dec_rs1en = 1'b1; dec_rs2en = 1'b1; dec_imm = imm_b;
      end
      OPC_LOAD: begin
        dec_grp = GRP_AGU; dec_rs1en = 1'b1; dec_rdwen = 1'b1; dec_imm = imm_i;
      end
      OPC_STORE: begin
        dec_grp = GRP_AGU; dec_rs1en = 1'b1; dec_rs2en = 1'b1; dec_imm = imm_s;
      end
      OPC_OP_IMM: begin
        dec_rs1en = 1'b1;
        dec_rdwen = 1'b1;
        dec_imm   = imm_i;
        // Shift-immediates carry funct7 in the upper immediate bits.
        if ((funct3 == 3'b001) && (funct7 != F7_BASE)) dec_ill = 1'b1;
        if ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT)) dec_ill = 1'b1;
      end
      OPC_OP: begin
        dec_rs1en = 1'b1;
        dec_rs2en = 1'b1;
        dec_rdwen = 1'b1;
        if (funct7 == F7_ALT) dec_ill = !((funct3 == 3'b000) || (funct3 == 3'b101));
`ifdef DECQ_MULDIV_EN
        else if (funct7 == F7_MD) dec_grp = GRP_MDV;
`endif
        else if (funct7 != F7_BASE) dec_ill = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
    if ((instr == 32'h0000_0000) || (instr == 32'hFFFF_FFFF)) dec_ill = 1'b1;
    if (dec_ill) begin
      dec_grp   = GRP_ALU;
      dec_bjp   = 1'b0;
      dec_rs1en = 1'b0;
      dec_rs2en = 1'b0;
      dec_rdwen = 1'b0;
      dec_imm   = '0;
    end
    if (!o_valid) begin
      dec_ill   = 1'b0;
      dec_grp   = GRP_ALU;
      dec_bjp   = 1'b0;
      dec_rs1en = 1'b0;
      dec_rs2en = 1'b0;
      dec_rdwen = 1'b0;
      dec_imm   = '0;
    end
  end

  assign o_pc         = o_valid ? head[32 +: PC_W] : '0;
  assign o_prdt_taken = o_valid & head[EW-1];
  assign o_rs1en      = dec_rs1en;
  assign o_rs2en      = dec_rs2en;
  assign o_rdwen      = dec_rdwen;
  assign o_rs1idx     = dec_rs1en ? instr[19:15] : 5'd0;
  assign o_rs2idx     = dec_rs2en ? instr[24:20] : 5'd0;
  assign o_rdidx      = dec_rdwen ? instr[11:7]  : 5'd0;
  assign o_grp        = dec_grp;
  assign o_imm        = dec_imm;
  assign o_illegal    = dec_ill;
  assign o_bjp        = dec_bjp;
  assign o_cnt        = cnt_q;
  assign o_ill_cnt    = ill_cnt_q;

endmodule

// File: doc/exu_decq.md
EXU_DECQ -- requirements
Module: exu_decq

Interface
REQ-001 SHALL have parameter DEPTH, default 2, queue entries (power of 2, >=2).
REQ-002 SHALL have parameter PC_W, default 32, PC width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  discard all queued entries.
REQ-006 SHALL have ports i_valid input 1 / i_ready output 1  enqueue handshake.
REQ-007 SHALL have ports i_instr input 32 / i_pc input PC_W / i_prdt_taken input 1  fetched instruction, PC, predicted-taken flag.
REQ-008 SHALL have ports o_valid output 1 / o_ready input 1  dequeue handshake.
REQ-009 SHALL have ports o_pc output PC_W / o_prdt_taken output 1  head PC and prediction.
REQ-010 SHALL have ports o_rs1en, o_rs2en, o_rdwen output 1 each / o_rs1idx, o_rs2idx, o_rdidx output 5 each  regfile controls.
REQ-011 SHALL have port o_grp  output 2  group: 00 ALU, 01 BJP, 10 AGU, 11 MULDIV.
REQ-012 SHALL have ports o_imm output 32 / o_illegal output 1 / o_bjp output 1  sign-extended immediate, illegal flag, branch/jump flag.
REQ-013 SHALL have port o_cnt  output $clog2(DEPTH)+1  occupancy.
REQ-014 SHALL have port o_ill_cnt  output 16  illegal instructions dequeued.

Function
REQ-015 SHALL store raw {instr, pc, prdt} in a circular FIFO; decode SHALL be combinational on the head entry only.
REQ-016 SHALL push on i_valid&i_ready; i_ready = (o_cnt<DEPTH), independent of o_ready.
REQ-017 SHALL pop on o_valid&o_ready; o_valid = (o_cnt!=0).
REQ-018 Latency: an entry pushed into an empty queue at edge N SHALL appear on o_valid after edge N.
REQ-019 Simultaneous push and pop SHALL leave o_cnt unchanged; pointers wrap modulo DEPTH.
REQ-020 While o_valid&~o_ready, all o_* decode outputs SHALL hold stable.
REQ-021 Decode: RV32I lui/auipc/op_imm/op -> ALU; jal/jalr/branch -> BJP, o_bjp=1; load/store -> AGU; op with funct7=0000001 -> MULDIV.
REQ-022 Immediates: I for jalr/op_imm/load, S store, B branch, U lui/auipc, J jal, else 0.
REQ-023 rs1en=0 for lui/auipc/jal; rs2en=1 for branch/store/op; rdwen=0 for branch/store and any illegal.
REQ-024 o_illegal SHALL be 1 for 0x00000000, 0xFFFFFFFF, unrecognised opcode, op/op_imm with invalid funct7.
REQ-025 Illegal entries SHALL still dequeue normally; o_grp=00, o_imm=0.
REQ-026 o_ill_cnt SHALL increment on each pop with o_illegal=1, saturating at 0xFFFF.
REQ-027 flush SHALL zero pointers and o_cnt at next edge; a push in the flush cycle SHALL be dropped; o_ill_cnt unaffected.
REQ-028 When o_valid=0, all decode outputs SHALL be driven 0.

Reset
REQ-029 rst_n low SHALL immediately clear pointers, o_cnt, o_ill_cnt; o_valid=0, i_ready=1; FIFO data need not be cleared.
REQ-030 Reset mid-operation SHALL discard all entries; first push after release behaves as REQ-018.

Configuration
REQ-031 With DECQ_MULDIV_EN defined, funct7=0000001 op instructions SHALL decode as MULDIV (o_grp=11).
REQ-032 Without DECQ_MULDIV_EN, those instructions SHALL be illegal (o_illegal=1, rdwen=0) and no MULDIV logic SHALL exist.

Verification
REQ-033 Reset, push 0x00500093 pc 0x100 -> next cycle o_valid=1, grp=00, rdidx=1, imm=5, rs1en=1, rs2en=0, rdwen=1, o_pc=0x100.
REQ-034 DEPTH=2, o_ready=0, push 3 back-to-back -> i_ready=0 after 2nd accept, o_cnt=2, 3rd held; raise o_ready -> outputs in push order.
REQ-035 Push 0x022081B3 -> with macro grp=11, illegal=0; without macro illegal=1, rdwen=0, o_ill_cnt 0->1 on pop.
REQ-036 Push 0x008000EF -> grp=01, o_bjp=1, imm=8, rdidx=1, rdwen=1, rs1en=0; push 0x00000000 -> illegal=1.
REQ-037 o_cnt=2 plus flush with i_valid=1 -> next cycle o_cnt=0, o_valid=0; rst_n pulse with o_cnt=2 -> o_valid=0 immediately, i_ready=1.
